// File: rtl/reg_file_sb_pkg.sv
// Shared types and reset constants for the scoreboarded register file.
// RF_R0_ZERO_EN (optional define) hardwires register 0 to zero in the top module.
package reg_file_sb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic   RST_BIT   = 1'b0;
    localparam state_t RST_STATE = ST_IDLE;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: reserve sets, writeback releases, sweep clears one entry per cycle.
// Also produces the registered rsv_err pulse and two combinational lookup ports.
module rf_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              sweep_i,
    input  logic [ADDR_W-1:0] sweep_idx_i,
    input  logic              rel_en_i,
    input  logic [ADDR_W-1:0] rel_addr_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic [ADDR_W-1:0] look_addr_a_i,
    input  logic [ADDR_W-1:0] look_addr_b_i,
    output logic              busy_a_o,
    output logic              busy_b_o,
    output logic              rsv_err_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic busy_q [NUM_REGS];
    logic rsv_ok;
    logic rsv_err_q;

    // A same-cycle release of the target register frees it before the reserve lands.
    assign rsv_ok = rsv_en_i && !sweep_i &&
                    (!busy_q[rsv_addr_i] || (rel_en_i && (rel_addr_i == rsv_addr_i)));

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            always_ff @(posedge CLK or negedge CLR) begin
                if (!CLR) begin
                    busy_q[gi] <= RST_BIT;
                end else if (sweep_i && (sweep_idx_i == ADDR_W'(gi))) begin
                    busy_q[gi] <= 1'b0;
                end else if (rsv_ok && (rsv_addr_i == ADDR_W'(gi))) begin
                    busy_q[gi] <= 1'b1;
                end else if (rel_en_i && (rel_addr_i == ADDR_W'(gi))) begin
                    busy_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rsv_err_q <= RST_BIT;
        end else begin
            rsv_err_q <= rsv_en_i && !rsv_ok;
        end
    end

    assign busy_a_o  = busy_q[look_addr_a_i];
    assign busy_b_o  = busy_q[look_addr_b_i];
    assign rsv_err_o = rsv_err_q;

endmodule

// File: rtl/reg_file_sb.sv
// 2R/1W register file with write-through bypass, busy scoreboard and sweep-clear FSM.
// Define RF_R0_ZERO_EN to hardwire register 0 to zero.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              busy_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_b,
    input  logic              clr_req,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              wr_err,
    output logic              rsv_err
);

    localparam int NUM_REGS = 2 ** ADDR_W;
`ifdef RF_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              wr_err_q;
    logic              sweep_done_q;
    logic [DATA_W-1:0] mem_q [NUM_REGS];

    logic idle;
    logic sweeping;
    logic wr_accept;
    logic rsv_fwd;
    logic bypass_a, bypass_b;
    logic zero_a, zero_b;
    logic sb_busy_a, sb_busy_b;

    assign idle      = (state_q == ST_IDLE);
    assign sweeping  = (state_q == ST_SWEEP);
    assign wr_accept = idle && wr_en && !(R0_ZERO && (wr_addr == '0));
    // Reserving the hardwired zero register is a silent no-op, but in SWEEP it still errors.
    assign rsv_fwd   = rsv_en && !(R0_ZERO && idle && (rsv_addr == '0));

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mem
            always_ff @(posedge CLK or negedge CLR) begin
                if (!CLR) begin
                    mem_q[gi] <= '0;
                end else if (sweeping && (idx_q == ADDR_W'(gi))) begin
                    mem_q[gi] <= '0;
                end else if (wr_accept && (wr_addr == ADDR_W'(gi))) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q      <= RST_STATE;
            idx_q        <= '0;
            wr_err_q     <= RST_BIT;
            sweep_done_q <= RST_BIT;
        end else begin
            wr_err_q     <= sweeping && wr_en;
            sweep_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_SWEEP;
                        idx_q   <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                        state_q      <= ST_IDLE;
                        idx_q        <= '0;
                        sweep_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .CLK           (CLK),
        .CLR           (CLR),
        .sweep_i       (sweeping),
        .sweep_idx_i   (idx_q),
        .rel_en_i      (wr_accept),
        .rel_addr_i    (wr_addr),
        .rsv_en_i      (rsv_fwd),
        .rsv_addr_i    (rsv_addr),
        .look_addr_a_i (rd_addr_a),
        .look_addr_b_i (rd_addr_b),
        .busy_a_o      (sb_busy_a),
        .busy_b_o      (sb_busy_b),
        .rsv_err_o     (rsv_err)
    );

    assign bypass_a = idle && wr_en && (wr_addr == rd_addr_a);
    assign bypass_b = idle && wr_en && (wr_addr == rd_addr_b);
    assign zero_a   = R0_ZERO && (rd_addr_a == '0);
    assign zero_b   = R0_ZERO && (rd_addr_b == '0);

    assign rd_data_a = (!rd_en_a || zero_a) ? '0 : (bypass_a ? wr_data : mem_q[rd_addr_a]);
    assign rd_data_b = (!rd_en_b || zero_b) ? '0 : (bypass_b ? wr_data : mem_q[rd_addr_b]);
    assign busy_a    = rd_en_a && !zero_a && !bypass_a && sb_busy_a;
    assign busy_b    = rd_en_b && !zero_b && !bypass_b && sb_busy_b;

    assign sweep_busy = sweeping;
    assign sweep_done = sweep_done_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with an array/queue-level reference model checked every cycle.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 16;
`ifdef RF_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic          CLK;
    logic          CLR;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic          rd_en_a, rd_en_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          busy_a, busy_b;
    logic          clr_req;
    logic          sweep_busy, sweep_done, wr_err, rsv_err;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .CLR(CLR),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .busy_a(busy_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .busy_b(busy_b),
        .clr_req(clr_req), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .wr_err(wr_err), .rsv_err(rsv_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Reference model: register contents, busy flags, sweep position, expected pulses.
    logic [31:0] m_mem  [NR];
    bit          m_busy [NR];
    bit          m_sweeping = 1'b0;
    int          m_pos = 0;
    bit          e_wr_err = 1'b0, e_rsv_err = 1'b0, e_done = 1'b0;

    initial for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_sweeping = 1'b0;
        m_pos      = 0;
        e_wr_err   = 1'b0;
        e_rsv_err  = 1'b0;
        e_done     = 1'b0;
    endtask

    task automatic model_step();
        bit r0_rsv;
        r0_rsv = R0Z && (rsv_addr == 0);
        e_done = 1'b0;
        if (m_sweeping) begin
            e_wr_err  = wr_en;
            e_rsv_err = rsv_en;
            m_mem[m_pos]  = '0;
            m_busy[m_pos] = 1'b0;
            if (m_pos == NR - 1) begin
                m_sweeping = 1'b0;
                m_pos      = 0;
                e_done     = 1'b1;
            end else begin
                m_pos++;
            end
        end else begin
            e_wr_err  = 1'b0;
            e_rsv_err = rsv_en && !r0_rsv && m_busy[rsv_addr] &&
                        !(wr_en && (wr_addr == rsv_addr) && !(R0Z && wr_addr == 0));
            if (wr_en && !(R0Z && wr_addr == 0)) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_en && !r0_rsv && !e_rsv_err) m_busy[rsv_addr] = 1'b1;
            if (clr_req) begin
                m_sweeping = 1'b1;
                m_pos      = 0;
            end
        end
    endtask

    always @(posedge CLK or negedge CLR) begin
        if (!CLR) model_reset();
        else      model_step();
    end

    function automatic logic [31:0] exp_rd(input logic en, input logic [AW-1:0] a);
        if (!en) return '0;
        if (R0Z && a == 0) return '0;
        if (!m_sweeping && wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic en, input logic [AW-1:0] a);
        if (!en) return 1'b0;
        if (R0Z && a == 0) return 1'b0;
        if (!m_sweeping && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge CLK) begin
        check("rd_data_a",  rd_data_a,  exp_rd(rd_en_a, rd_addr_a));
        check("rd_data_b",  rd_data_b,  exp_rd(rd_en_b, rd_addr_b));
        check("busy_a",     busy_a,     exp_busy(rd_en_a, rd_addr_a));
        check("busy_b",     busy_b,     exp_busy(rd_en_b, rd_addr_b));
        check("sweep_busy", sweep_busy, m_sweeping);
        check("sweep_done", sweep_done, e_done);
        check("wr_err",     wr_err,     e_wr_err);
        check("rsv_err",    rsv_err,    e_rsv_err);
    end

    int sweep_cycles = 0;
    int done_pulses  = 0;
    always @(negedge CLK) begin
        if (sweep_busy === 1'b1) sweep_cycles++;
        if (sweep_done === 1'b1) done_pulses++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit seen;
        int done_before;
        CLR = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
        rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
        repeat (2) @(posedge CLK);
        #1 CLR = 1'b1;

        // 1: reset state
        rd_en_a = 1'b1; rd_addr_a = 4'd3; rd_en_b = 1'b1; rd_addr_b = 4'd9;
        @(negedge CLK);
        check("t1_rd_a", rd_data_a, 32'h0);
        check("t1_rd_b", rd_data_b, 32'h0);
        check("t1_busy_a", busy_a, 1'b0);
        check("t1_sweep_busy", sweep_busy, 1'b0);

        // 2: write then read, then bypass
        tick(); wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0000_0307;
        tick(); wr_en = 1'b0; rd_addr_a = 4'd5;
        @(negedge CLK);
        check("t2_r5", rd_data_a, 32'h0000_0307);
        tick(); wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'hFFFF_FFFF; rd_addr_b = 4'd15;
        @(negedge CLK);
        check("t2_bypass", rd_data_b, 32'hFFFF_FFFF);
        tick(); wr_en = 1'b0;

        // 3: scoreboard reserve/release
        rsv_en = 1'b1; rsv_addr = 4'd4; rd_addr_a = 4'd4;
        tick(); rsv_en = 1'b0;
        @(negedge CLK);
        check("t3_busy_set", busy_a, 1'b1);
        tick(); rsv_en = 1'b1;
        tick(); rsv_en = 1'b0;
        @(negedge CLK);
        check("t3_rsv_err", rsv_err, 1'b1);
        check("t3_busy_kept", busy_a, 1'b1);
        tick(); wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h1400_0006;
        tick(); wr_en = 1'b0;
        @(negedge CLK);
        check("t3_released", busy_a, 1'b0);
        check("t3_data", rd_data_a, 32'h1400_0006);
        tick(); wr_en = 1'b1; rsv_en = 1'b1;
        tick(); wr_en = 1'b0; rsv_en = 1'b0;
        @(negedge CLK);
        check("t3_rersv_busy", busy_a, 1'b1);
        check("t3_rersv_noerr", rsv_err, 1'b0);

        // 4: sweep-clear with a rejected write in sweep cycle 3
        tick(); wr_en = 1'b1; wr_addr = 4'd11; wr_data = 32'h1680_0005;
        tick(); wr_en = 1'b0; clr_req = 1'b1; sweep_cycles = 0;
        tick(); clr_req = 1'b0;
        tick(); tick();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5A5_A5A5;
        tick(); wr_en = 1'b0;
        @(negedge CLK);
        check("t4_wr_err", wr_err, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge CLK);
            if (sweep_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_done_seen", seen, 1'b1);
        check("t4_sweep_cycles", sweep_cycles, 16);
        tick(); rd_addr_a = 4'd11; rd_addr_b = 4'd5;
        @(negedge CLK);
        check("t4_r11", rd_data_a, 32'h0);
        check("t4_r5", rd_data_b, 32'h0);
        check("t4_busy_a", busy_a, 1'b0);
        tick(); rd_addr_a = 4'd4; rd_addr_b = 4'd7;
        @(negedge CLK);
        check("t4_r4_busy", busy_a, 1'b0);
        check("t4_lost_write", rd_data_b, 32'h0);

        // 5: reset in the middle of a sweep
        tick(); wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h0000_0055; rd_addr_a = 4'd2;
        tick(); wr_en = 1'b0; clr_req = 1'b1;
        tick(); clr_req = 1'b0;
        repeat (4) tick();
        done_before = done_pulses;
        CLR = 1'b0;
        #1;
        check("t5_sweep_busy", sweep_busy, 1'b0);
        check("t5_r2", rd_data_a, 32'h0);
        tick(); CLR = 1'b1;
        repeat (20) tick();
        check("t5_no_done", done_pulses, done_before);

        // 6: register 0 behaviour
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEAD_BEEF;
        tick(); wr_en = 1'b0; rd_addr_a = 4'd0;
        @(negedge CLK);
        check("t6_r0", rd_data_a, R0Z ? 32'h0 : 32'hDEAD_BEEF);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
